// File: rtl/qkd_pkg.sv
// Shared QKD definitions: default stream geometry, basis encoding and a popcount helper.
// Used by the key_sifter_stream slice (interface, lane_compactor, top).
package qkd_pkg;

    localparam int unsigned KEY_W_DEF = 16;
    localparam int unsigned LANES_DEF = 8;
    localparam int unsigned CNT_W_DEF = 16;

    // Widest vector popcount() accepts; callers zero-extend into it.
    localparam int unsigned POP_MAX_W = 64;

    typedef enum logic {
        BASIS_RECT = 1'b0,
        BASIS_DIAG = 1'b1
    } basis_e;

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < POP_MAX_W; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/key_sifter_stream_if.sv
// Bundle of the sifter's beat-input and key-output handshakes plus statistics.
// slave = the sifting engine, master = the upstream/downstream environment.
interface key_sifter_stream_if
    import qkd_pkg::*;
#(
    parameter int unsigned KEY_W = KEY_W_DEF,
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);

    localparam int unsigned ERR_W = $clog2(KEY_W + 1);

    logic             in_valid;
    logic             in_ready;
    logic [LANES-1:0] in_sbit;
    logic [LANES-1:0] in_sbasis;
    logic [LANES-1:0] in_rbasis;
    logic [LANES-1:0] in_rbit;

    logic             key_valid;
    logic             key_ready;
    logic [KEY_W-1:0] key;
    logic [ERR_W-1:0] key_err;
    logic [CNT_W-1:0] key_cnt;
    logic [CNT_W-1:0] discard_cnt;

    modport slave (
        input  in_valid, in_sbit, in_sbasis, in_rbasis, in_rbit, key_ready,
        output in_ready, key_valid, key, key_err, key_cnt, discard_cnt
    );

    modport master (
        output in_valid, in_sbit, in_sbasis, in_rbasis, in_rbit, key_ready,
        input  in_ready, key_valid, key, key_err, key_cnt, discard_cnt
    );

endinterface

// File: rtl/lane_compactor.sv
// Combinational lane compactor: gathers data bits of set mask lanes into the
// low end of comp in ascending lane order and reports how many were kept.
module lane_compactor
    import qkd_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEF
) (
    input  logic [LANES-1:0]             mask,
    input  logic [LANES-1:0]             data,
    output logic [LANES-1:0]             comp,
    output logic [$clog2(LANES+1)-1:0]   count
);

    localparam int unsigned CB = $clog2(LANES + 1);

    always_comb begin
        int unsigned k;
        comp = '0;
        k    = 0;
        // Shift-by-running-count avoids a variable bit-select on the output.
        for (int unsigned i = 0; i < LANES; i++) begin
            if (mask[i]) begin
                comp = comp | (LANES'(data[i]) << k);
                k    = k + 1;
            end
        end
        count = CB'(k);
    end

endmodule

// File: rtl/key_sifter_stream.sv
// Streaming BB84 sifter: keeps basis-matched lanes, packs them LSB-first into KEY_W-bit keys.
// Optional per-key error count (QBER) enabled by defining KEY_SIFTER_QBER_EN.
module key_sifter_stream
    import qkd_pkg::*;
#(
    parameter int unsigned KEY_W = KEY_W_DEF,
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    key_sifter_stream_if.slave  bus
);

    localparam int unsigned BUF_W  = KEY_W + LANES;
    localparam int unsigned FILL_W = $clog2(KEY_W + LANES);
    localparam int unsigned LCNT_W = $clog2(LANES + 1);
    localparam int unsigned ERR_W  = $clog2(KEY_W + 1);
    localparam int unsigned SUM_W  = CNT_W + 1;

    if (LANES < 1 || LANES > KEY_W) begin : g_bad_lanes
        $error("key_sifter_stream: LANES must lie in 1..KEY_W");
    end
    if (KEY_W > POP_MAX_W) begin : g_bad_key_w
        $error("key_sifter_stream: KEY_W exceeds popcount width");
    end

    logic [BUF_W-1:0]  key_buf, key_buf_nxt, key_base;
    logic [FILL_W-1:0] fill, fill_nxt, fill_base;
    logic [CNT_W-1:0]  key_cnt_q, key_cnt_nxt;
    logic [CNT_W-1:0]  discard_q, discard_nxt;
    logic [SUM_W-1:0]  discard_sum;
    logic [LCNT_W-1:0] drop_cnt;

    logic              key_valid_int;
    logic              in_ready_int;
    logic              pop;
    logic              accept;

    logic [LANES-1:0]  match;
    logic [LANES-1:0]  comp_bits;
    logic [LCNT_W-1:0] comp_cnt;
    logic [KEY_W-1:0]  key_mask;

    assign match         = ~(bus.in_sbasis ^ bus.in_rbasis);
    assign key_valid_int = (fill >= FILL_W'(KEY_W));
    assign in_ready_int  = !key_valid_int || bus.key_ready;
    assign pop           = key_valid_int && bus.key_ready;
    assign accept        = bus.in_valid && in_ready_int;

    lane_compactor #(.LANES(LANES)) u_comp_key (
        .mask  (match),
        .data  (bus.in_sbit),
        .comp  (comp_bits),
        .count (comp_cnt)
    );

    // Pop is applied first so a same-cycle append lands right after the carried-over bits.
    always_comb begin
        fill_base   = pop ? (fill - FILL_W'(KEY_W)) : fill;
        key_base    = pop ? (key_buf >> KEY_W) : key_buf;
        key_buf_nxt = key_base;
        fill_nxt    = fill_base;
        if (accept) begin
            key_buf_nxt = key_base | (BUF_W'(comp_bits) << fill_base);
            fill_nxt    = fill_base + FILL_W'(comp_cnt);
        end
    end

    always_comb begin
        drop_cnt    = LCNT_W'(LANES) - comp_cnt;
        discard_sum = {1'b0, discard_q} + SUM_W'(drop_cnt);
        discard_nxt = discard_q;
        if (accept) begin
            discard_nxt = discard_sum[CNT_W] ? '1 : discard_sum[CNT_W-1:0];
        end
        key_cnt_nxt = pop ? (key_cnt_q + CNT_W'(1)) : key_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_buf   <= '0;
            fill      <= '0;
            key_cnt_q <= '0;
            discard_q <= '0;
        end else begin
            key_buf   <= key_buf_nxt;
            fill      <= fill_nxt;
            key_cnt_q <= key_cnt_nxt;
            discard_q <= discard_nxt;
        end
    end

    // Bits at or above fill never reach the key port, even for a partial word.
    always_comb begin
        key_mask = '0;
        for (int unsigned i = 0; i < KEY_W; i++) begin
            key_mask[i] = (FILL_W'(i) < fill);
        end
    end

    assign bus.in_ready    = in_ready_int;
    assign bus.key_valid   = key_valid_int;
    assign bus.key         = key_buf[KEY_W-1:0] & key_mask;
    assign bus.key_cnt     = key_cnt_q;
    assign bus.discard_cnt = discard_q;

`ifdef KEY_SIFTER_QBER_EN
    logic [BUF_W-1:0]  err_buf, err_buf_nxt, err_base;
    logic [LANES-1:0]  err_comp;
    logic [LCNT_W-1:0] unused_err_cnt;

    lane_compactor #(.LANES(LANES)) u_comp_err (
        .mask  (match),
        .data  (bus.in_sbit ^ bus.in_rbit),
        .comp  (err_comp),
        .count (unused_err_cnt)
    );

    always_comb begin
        err_base    = pop ? (err_buf >> KEY_W) : err_buf;
        err_buf_nxt = err_base;
        if (accept) begin
            err_buf_nxt = err_base | (BUF_W'(err_comp) << fill_base);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_buf <= '0;
        end else begin
            err_buf <= err_buf_nxt;
        end
    end

    assign bus.key_err = ERR_W'(popcount(POP_MAX_W'(err_buf[KEY_W-1:0] & key_mask)));
`else
    logic unused_rbit;
    assign unused_rbit = ^bus.in_rbit;
    assign bus.key_err = '0;
`endif

    a_fill_bound: assert property (@(posedge clk) disable iff (rst)
        fill <= FILL_W'(KEY_W + LANES - 1));

    a_key_hold: assert property (@(posedge clk) disable iff (rst)
        (bus.key_valid && !bus.key_ready) |=> $stable(bus.key));

endmodule

// File: doc/key_sifter_stream.md
Name: key_sifter_stream

Overview:
- Streaming BB84 sifting engine; parametrised successor of the single-shot 80-bit sifter.
- Accepts LANES qubit records per beat: sender bit, sender basis, receiver basis.
- Keeps lanes whose bases match, compacts them in lane order, and packs them LSB-first into KEY_W-bit keys.
- Each key is emitted over a valid/ready handshake. Surplus bits carry over into the next key. Sits between the basis-reconciliation front end and the key buffer/encryptor.

Parameters:
- KEY_W, 16, sifted key width per output word; must be >= LANES.
- LANES, 8, qubit records per input beat; 1..KEY_W.
- CNT_W, 16, width of statistics counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  engine can accept a beat.
- in_sbit  input  LANES  sender raw bits; lane 0 is oldest.
- in_sbasis  input  LANES  sender basis per lane.
- in_rbasis  input  LANES  receiver basis per lane.
- in_rbit  input  LANES  receiver measured bits; used only with the QBER feature.
- key_valid  output  1  key word available.
- key_ready  input  1  downstream accepts key.
- key  output  KEY_W  sifted key; bit 0 is the first sifted bit.
- key_err  output  $clog2(KEY_W+1)  mismatching sifted bits in the current key.
- key_cnt  output  CNT_W  keys delivered, wraps.
- discard_cnt  output  CNT_W  basis-mismatched lanes discarded, saturates at all-ones.

Behaviour:
- Storage: register buf[KEY_W+LANES-1:0] plus fill count, width $clog2(KEY_W+LANES).
- Input handshake: a beat is accepted when in_valid && in_ready, with in_ready = !key_valid || key_ready (fall-through on pop).
- Key output is combinational from registers:
  - key_valid = (fill >= KEY_W)
  - key = buf[KEY_W-1:0]
  - key is held stable while key_valid && !key_ready.
- Pop: when key_valid && key_ready, buf shifts right by KEY_W and fill -= KEY_W; leftover bits (<= LANES-1) move to bit 0 upward.
- Append on an accepted beat:
  - m[i] = (in_sbasis[i] == in_rbasis[i]).
  - The matched in_sbit lanes are compacted in ascending lane order and written at position fill (post-pop fill if a pop occurs in the same cycle).
  - fill += popcount(m).
- Simultaneous pop and append in one cycle is legal and lossless.
- Bound: fill <= KEY_W+LANES-1 is guaranteed by LANES <= KEY_W; an elaboration-time check rejects violations.
- Latency: a key completed by beat N asserts key_valid on the cycle after that beat's handshake.
- Beats with zero matches are accepted and change only discard_cnt.
- Counters:
  - discard_cnt += LANES - popcount(m) per accepted beat, saturating.
  - key_cnt += 1 per pop, wrapping.
- Reset: all of the following clear to 0 on the next edge, including mid-key; partial bits are lost:
  - buf, fill, key_cnt, discard_cnt, key_err accumulator
  - key_valid = 0
  - in_ready = 1
- Unused bits of buf above fill are don't-care internally but must be zero-masked before driving key.

Optional Feature:
- Macro: KEY_SIFTER_QBER_EN.
- Defined:
  - A parallel error buffer tracks, per sifted bit, (in_sbit ^ in_rbit).
  - key_err is the popcount of the error bits aligned with the current key word.
  - It pops and carries over exactly like buf.
- Undefined:
  - in_rbit is ignored.
  - key_err is tied to 0 and no error buffer is synthesised.

Decomposition:
- Shared package qkd_pkg:
  - default KEY_W/LANES localparams
  - basis encoding constants BASIS_RECT=0, BASIS_DIAG=1
  - popcount function
- One sub-module: lane_compactor. Combinational; takes the LANES-bit mask and data and produces compacted bits plus a count. It is instantiated twice when QBER is enabled.

Test Plan:
- All bases match; beats in_sbit=0xA5, then 0x3C; key_ready=1 → key_valid after the second beat with key=0x3CA5; key_cnt=1; discard_cnt=0.
- in_sbasis=0x00, in_rbasis=0xAA, in_sbit=0xFF ×4 beats → 4 bits kept per beat; key=0xFFFF after the 4th beat; discard_cnt=16.
- Backpressure: key_ready=0 once key_valid → in_ready=0; key stays stable for 10 cycles. Then raise key_ready → pop, and in_ready=1 in the same cycle.
- Carry-over with simultaneous pop/append: all-match beats 0x01, 0x02, then 0x03 while key_ready=1 → first key=0x0201; next key low byte=0x03 after one more beat 0x04 → key=0x0403.
- rst pulsed after one beat of a partial key → fill=0 and counters=0. The next two beats 0x11, 0x22 yield key=0x2211.
- KEY_SIFTER_QBER_EN: all-match, in_sbit=0xA5/0x3C, in_rbit=0xA4/0x3C → key_err=1. With the macro undefined → key_err=0.
